// File: rtl/rom_seq_pkg.sv
// rtl/rom_seq_pkg.sv - shared widths and FSM state type for the ROM sequential reader
package rom_seq_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 7;
   localparam int SUM_W  = DATA_W + ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/rom_seq_reader.sv
// rtl/rom_seq_reader.sv - streams a burst of consecutive ROM words with valid/ready and a running sum
import rom_seq_pkg::*;

module rom_seq_reader #(
   parameter int ADDR_W = rom_seq_pkg::ADDR_W,
   parameter int DATA_W = rom_seq_pkg::DATA_W,
   parameter int LEN_W  = rom_seq_pkg::LEN_W,
   parameter int SUM_W  = rom_seq_pkg::SUM_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] addr_o,
   input  logic [DATA_W-1:0] rom_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [SUM_W-1:0]  sum_o
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [LEN_W-1:0]    rem_q,   rem_d;
   logic [DATA_W-1:0]   data_q,  data_d;
   logic                valid_q, valid_d;
   logic                last_q,  last_d;
   logic                done_q,  done_d;
   logic [SUM_W-1:0]    sum_q,   sum_d;
   logic                hs;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      hs      = valid_q && ready_i;

      // A handshake retires the held word; a load below in the same cycle overrides the clear.
      if (hs) begin
         sum_d   = sum_q + SUM_W'(data_q);
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sum_d = '0;
               if (len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = base_i;
                  rem_d   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!valid_q || ready_i) begin
               data_d  = rom_i;
               valid_d = 1'b1;
               last_d  = (rem_q == ONE);
               addr_d  = addr_q + ADDR_W'(1);
               rem_d   = rem_q - ONE;
               if (rem_q == ONE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (hs) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
      end
   end

   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign done_o  = done_q;
   assign sum_o   = sum_q;
   assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_seq_reader.sv
// tb/tb_rom_seq_reader.sv - randomized self-checking bench for rom_seq_reader against a burst-level model
module tb_rom_seq_reader;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [5:0]  base_i;
   logic [6:0]  len_i;
   logic [5:0]  addr_o;
   logic [15:0] rom_i;
   logic [15:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        last_o;
   logic        busy_o;
   logic        done_o;
   logic [21:0] sum_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] rom_model(input int a);
      if (a == 0) return 16'd365;
      if (a == 1) return 16'd364;
      return 16'(300 + a);
   endfunction

   assign rom_i = rom_model(int'(addr_o));

   rom_seq_reader dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .base_i  (base_i),
      .len_i   (len_i),
      .addr_o  (addr_o),
      .rom_i   (rom_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .last_o  (last_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .sum_o   (sum_o)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge; that cycle is cycle 0 (start_i high).
   // mode 0: always ready, 1: random ready + ignored start pulses, 2: stall 5 cycles at first valid.
   task automatic run_burst(input int b, input int l, input int mode,
                            output int first_cyc, output int done_cyc,
                            output int last_word, output int nw);
      int q[$];
      int n, acc, exp_sum, run_sum, cyc, stall_left, exp_d;
      bit hs, prev_stall;
      int pdata, paddr, plast;
      n = (l > 64) ? 64 : l;
      exp_sum = 0;
      for (int i = 0; i < n; i++) begin
         q.push_back(int'(rom_model((b + i) % 64)));
         exp_sum += int'(rom_model((b + i) % 64));
      end
      first_cyc = -1; done_cyc = -1; last_word = -1; nw = 0;
      acc = 0; run_sum = 0; prev_stall = 0; pdata = 0; paddr = 0; plast = 0;
      stall_left = (mode == 2) ? 5 : 0;

      start_i = 1'b1; base_i = 6'(b); len_i = 7'(l); ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;

      if (n == 0) begin
         done_cyc = 1;
         chk("zlen_done", done_o, 1);
         chk("zlen_valid", valid_o, 0);
         chk("zlen_sum", sum_o, 0);
         chk("zlen_busy", busy_o, 0);
         @(negedge clk_i);
         chk("zlen_done_end", done_o, 0);
         chk("zlen_valid2", valid_o, 0);
         return;
      end

      while (done_cyc < 0 && cyc < 400) begin
         chk("busy", busy_o, 1);
         chk("done_early", done_o, 0);
         chk("sum_run", sum_o, run_sum);
         chk("addr", addr_o, (b + acc + int'(valid_o)) % 64);
         if (prev_stall) begin
            chk("hold_valid", valid_o, 1);
            chk("hold_data", data_o, pdata);
            chk("hold_last", last_o, plast);
            chk("hold_addr", addr_o, paddr);
         end
         if (valid_o && first_cyc < 0) first_cyc = cyc;

         case (mode)
            1: ready_i = ($urandom_range(0, 3) != 0);
            2: begin
               if (valid_o && stall_left > 0) begin
                  ready_i = 1'b0;
                  stall_left--;
               end else begin
                  ready_i = 1'b1;
               end
            end
            default: ready_i = 1'b1;
         endcase

         hs = valid_o && ready_i;
         if (hs) begin
            exp_d = q.pop_front();
            chk("data", data_o, exp_d);
            chk("last", last_o, (q.size() == 0));
            acc++; nw++;
            run_sum += exp_d;
            last_word = int'(data_o);
         end
         prev_stall = valid_o && !ready_i;
         pdata = int'(data_o); paddr = int'(addr_o); plast = int'(last_o);

         if (mode == 1) begin
            start_i = 1'($urandom_range(0, 1));
            base_i  = 6'($urandom);
            len_i   = 7'($urandom);
         end else begin
            start_i = 1'b0;
         end

         @(negedge clk_i);
         cyc++;
         if (hs && q.size() == 0) begin
            done_cyc = cyc;
            start_i = 1'b0;
            chk("done", done_o, 1);
            chk("busy_end", busy_o, 0);
            chk("valid_end", valid_o, 0);
            chk("sum_final", sum_o, exp_sum);
         end
      end
      if (done_cyc < 0) chk("timeout", 0, 1);
      start_i = 1'b0; ready_i = 1'b1;
      @(negedge clk_i);
      chk("done_pulse_end", done_o, 0);
      chk("sum_hold", sum_o, exp_sum);
      chk("idle_valid", valid_o, 0);
   endtask

   int fc, dc, lw, nw;

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_valid", valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_sum", sum_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_last", last_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run_burst(2, 3, 0, fc, dc, lw, nw);
      chk("b1_first_cyc", fc, 2);
      chk("b1_done_cyc", dc, 5);
      chk("b1_sum", sum_o, 909);
      chk("b1_last_word", lw, 304);

      run_burst(62, 4, 0, fc, dc, lw, nw);
      chk("b2_sum", sum_o, 1454);
      chk("b2_last_word", lw, 364);

      run_burst(2, 3, 2, fc, dc, lw, nw);
      chk("b3_first_cyc", fc, 2);
      chk("b3_sum", sum_o, 909);

      run_burst(9, 0, 0, fc, dc, lw, nw);
      chk("b4_words", nw, 0);

      run_burst(0, 100, 0, fc, dc, lw, nw);
      chk("b5_words", nw, 64);
      chk("b5_last_word", lw, 363);

      for (int k = 0; k < 24; k++) begin
         run_burst($urandom_range(0, 63), $urandom_range(0, 100), $urandom_range(0, 2),
                   fc, dc, lw, nw);
         if (nw != 0) chk("rnd_first_cyc", fc, 2);
      end

      start_i = 1'b1; base_i = 6'd10; len_i = 7'd20; ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("pre_rst_valid", valid_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_valid", valid_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_sum", sum_o, 0);
      chk("mid_rst_addr", addr_o, 0);
      chk("mid_rst_last", last_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("post_rst_busy", busy_o, 0);
         chk("post_rst_valid", valid_o, 0);
      end

      run_burst(5, 7, 1, fc, dc, lw, nw);
      chk("recover_words", nw, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rom_seq_reader.md
ROM_SEQ_READER -- requirements
Module: rom_seq_reader

Interface
REQ-001 Parameter ADDR_W, default 6, ROM address width.
REQ-002 Parameter DATA_W, default 16, ROM word width.
REQ-003 Parameter LEN_W, default 7, burst-length width; maximum burst is 2**ADDR_W words.
REQ-004 Parameter SUM_W, default 22, running-sum width, which is DATA_W+ADDR_W.
REQ-005 Port clk_i, input, 1 bit: the single clock, rising-edge.
REQ-006 Port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port start_i, input, 1 bit: burst request, sampled only in IDLE.
REQ-008 Port base_i, input, ADDR_W bits: first ROM address of the burst.
REQ-009 Port len_i, input, LEN_W bits: number of words in the burst.
REQ-010 Port addr_o, output, ADDR_W bits: registered address driven to the combinational ROM.
REQ-011 Port rom_i, input, DATA_W bits: ROM word for addr_o, valid in the same cycle.
REQ-012 Port data_o, output, DATA_W bits: streamed word.
REQ-013 Port valid_o, output, 1 bit: data_o is valid.
REQ-014 Port ready_i, input, 1 bit: downstream accepts data_o.
REQ-015 Port last_o, output, 1 bit: data_o is the final word of the burst.
REQ-016 Port busy_o, output, 1 bit: a burst is in progress.
REQ-017 Port done_o, output, 1 bit: one-cycle pulse at burst completion.
REQ-018 Port sum_o, output, SUM_W bits: unsigned sum of the words accepted in the current or last burst.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-020 IDLE with start_i=1 and len_i!=0: latch addr_q<=base_i, set rem<=min(len_i,64), clear sum_o, enter RUN.
REQ-021 IDLE with start_i=1 and len_i==0: clear sum_o, pulse done_o in the next cycle, stay in IDLE, emit no data.
REQ-022 len_i values above 64 SHALL clamp to 64.
REQ-023 start_i SHALL be ignored in RUN and DRAIN.
REQ-024 busy_o SHALL equal (state!=IDLE).
REQ-025 In RUN, a load SHALL occur when (!valid_o || ready_i).
REQ-026 Each load: data_o<=rom_i; valid_o<=1; last_o<=(rem==1); addr_q<=addr_q+1 modulo 2**ADDR_W, so 63 wraps to 0; rem<=rem-1.
REQ-027 A load that takes rem to 0 SHALL move the FSM to DRAIN.
REQ-028 A handshake is (valid_o && ready_i); a handshake with no simultaneous load SHALL clear valid_o and last_o.
REQ-029 The held data_o, last_o and addr_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-030 On every handshake, sum_o SHALL take sum_o+data_o, zero-extended.
REQ-031 In DRAIN, the handshake of the last word SHALL cause done_o=1 for exactly the next cycle and a return to IDLE.
REQ-032 Latency: with start_i accepted in cycle 0, the first valid_o SHALL appear in cycle 2.
REQ-033 Throughput: one word per cycle while ready_i=1.
REQ-034 sum_o SHALL hold its value after done_o until the next accepted start_i.

Reset
REQ-035 rst_ni=0 SHALL asynchronously force state=IDLE, addr_o=0, rem=0, data_o=0, valid_o=0, last_o=0, done_o=0, busy_o=0 and sum_o=0, including mid-burst.
REQ-036 The block SHALL wait for a new start_i after reset release.

Structure
REQ-037 Package rom_seq_pkg SHALL hold ADDR_W, DATA_W, LEN_W, SUM_W and the state enum.
REQ-038 There SHALL be no sub-module: the FSM, counters and output register live in rom_seq_reader, and the ROM is instantiated beside it at top level.

Verification
The bench pairs the block with the team's 64x16 ROM model: addr0=365, addr1=364, addr n=300+n for n=2..63.
REQ-039 base=2, len=3, ready_i=1 -> data 302, 303, 304 in cycles 2-4; last_o with 304; sum_o=909; done_o in cycle 5.
REQ-040 base=62, len=4 -> addr_o 62, 63, 0, 1; data 362, 363, 365, 364; sum_o=1454.
REQ-041 base=2, len=3, ready_i=0 for 5 cycles after the first valid_o -> data_o holds 302, addr_o holds 3, and the stream then resumes with 303, 304.
REQ-042 len=0 -> done_o in cycle 1, valid_o never 1, sum_o=0; len=100, base=0 -> exactly 64 words, last_o on the word 363.
REQ-043 start_i pulsed mid-burst -> ignored; rst_ni=0 mid-burst -> valid_o, busy_o and sum_o read 0 before the next clock edge.
